// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing
//  Purpose  : Raster timing generator and output stage for the 800x600 path.
//             Produces raster coordinates and line/frame strobes for the
//             renderer, then re-times the returned colour together with
//             hsync/vsync through a PIPE_DELAY-deep alignment pipeline.
//  Ports    : clk         - pixel clock
//             rst         - asynchronous active-high reset
//             x, y        - current pixel column / line (registered counters)
//             o_active    - (x,y) lies in the visible area
//             line_start  - one-cycle pulse when x==0
//             frame_start - one-cycle pulse when x==0 and y==0
//             rgb_in      - renderer colour, PIPE_DELAY cycles behind x/y
//             hsync/vsync - sync outputs, asserted level SYNC_POL
//             vga_rgb     - colour to the DAC, forced to 0 in blanking
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing #(
   parameter int   H_ACTIVE   = 800,
   parameter int   H_FP       = 56,
   parameter int   H_SYNC     = 120,
   parameter int   H_BP       = 64,
   parameter int   V_ACTIVE   = 600,
   parameter int   V_FP       = 37,
   parameter int   V_SYNC     = 6,
   parameter int   V_BP       = 23,
   parameter logic SYNC_POL   = 1'b1,
   parameter int   PIPE_DELAY = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [10:0] x,
   output logic [9:0]  y,
   output logic        o_active,
   output logic        line_start,
   output logic        frame_start,
   input  logic [8:0]  rgb_in,
   output logic        hsync,
   output logic        vsync,
   output logic [8:0]  vga_rgb
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] c_h_last     = 11'(H_TOTAL - 1);
   localparam logic [10:0] c_h_active   = 11'(H_ACTIVE);
   localparam logic [10:0] c_hs_start   = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] c_hs_end     = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0]  c_v_last     = 10'(V_TOTAL - 1);
   localparam logic [9:0]  c_v_active   = 10'(V_ACTIVE);
   localparam logic [9:0]  c_vs_start   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  c_vs_end     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   // ------------------------------------------------------------------------
   // Raster counters. They reset to the last position of the frame so the
   // very first edge after reset lands on (0,0) and fires both strobes.
   // ------------------------------------------------------------------------
   logic [10:0] r_hcnt;
   logic [9:0]  r_vcnt;
   logic [10:0] w_h_next;
   logic [9:0]  w_v_next;
   logic        w_h_wrap;

   always_comb begin
      w_h_wrap = (r_hcnt == c_h_last);
      w_h_next = w_h_wrap ? 11'd0 : r_hcnt + 11'd1;
      w_v_next = r_vcnt;
      if (w_h_wrap) begin
         w_v_next = (r_vcnt == c_v_last) ? 10'd0 : r_vcnt + 10'd1;
      end
   end

   // x/y are registered from the next-count so they read (0,0) while the
   // internal counters sit at the end-of-frame reset position.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hcnt      <= c_h_last;
         r_vcnt      <= c_v_last;
         x           <= 11'd0;
         y           <= 10'd0;
         o_active    <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         r_hcnt      <= w_h_next;
         r_vcnt      <= w_v_next;
         x           <= w_h_next;
         y           <= w_v_next;
         o_active    <= (w_h_next < c_h_active) && (w_v_next < c_v_active);
         line_start  <= (w_h_next == 11'd0);
         frame_start <= (w_h_next == 11'd0) && (w_v_next == 10'd0);
      end
   end

   // ------------------------------------------------------------------------
   // Raw sync windows, aligned with x/y. Decoding from the registered
   // outputs keeps them inactive during reset, so no partial pulse can
   // enter the pipeline. vsync follows y, hence only changes at x==0.
   // ------------------------------------------------------------------------
   logic       w_hs_raw;
   logic       w_vs_raw;
   logic [2:0] w_raw;
   logic [2:0] w_dly;

   assign w_hs_raw = (x >= c_hs_start) && (x <= c_hs_end);
   assign w_vs_raw = (y >= c_vs_start) && (y <= c_vs_end);
   assign w_raw    = {w_hs_raw, w_vs_raw, o_active};

   // Alignment pipeline {hs, vs, active}, matching the renderer latency.
   generate
      if (PIPE_DELAY == 0) begin : g_no_delay
         assign w_dly = w_raw;
      end else begin : g_delay
         logic [2:0] r_pipe [PIPE_DELAY];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_pipe[0] <= 3'b000;
            end else begin
               r_pipe[0] <= w_raw;
            end
         end

         for (genvar i = 1; i < PIPE_DELAY; i++) begin : g_stage
            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  r_pipe[i] <= 3'b000;
               end else begin
                  r_pipe[i] <= r_pipe[i-1];
               end
            end
         end

         assign w_dly = r_pipe[PIPE_DELAY-1];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Output register: colour blanked outside the visible area.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vga_rgb <= 9'd0;
         hsync   <= ~SYNC_POL;
         vsync   <= ~SYNC_POL;
      end else begin
         vga_rgb <= w_dly[0] ? rgb_in : 9'd0;
         hsync   <= w_dly[2] ? SYNC_POL : ~SYNC_POL;
         vsync   <= w_dly[1] ? SYNC_POL : ~SYNC_POL;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing
//  Purpose  : Self-checking bench for vga_timing. Two instances with a
//             reduced raster (different PIPE_DELAY / SYNC_POL) are compared
//             every cycle against an arithmetic raster model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing;

   localparam int HA = 40;
   localparam int HF = 5;
   localparam int HS = 8;
   localparam int HB = 7;
   localparam int VA = 20;
   localparam int VF = 3;
   localparam int VS = 2;
   localparam int VB = 4;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;
   localparam int D_A = 2;
   localparam int D_B = 0;

   logic        clk = 1'b0;
   logic        rst;
   logic [8:0]  rgb_in = 9'd0;

   logic [10:0] xa, xb;
   logic [9:0]  ya, yb;
   logic        act_a, act_b, ls_a, ls_b, fs_a, fs_b;
   logic        hs_a, hs_b, vs_a, vs_b;
   logic [8:0]  rgb_a, rgb_b;

   int          n;          // edges since reset release, first edge = 0
   logic [8:0]  edge_rgb;   // rgb_in as seen by the most recent edge
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   vga_timing #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(1'b1), .PIPE_DELAY(D_A)
   ) dut_a (
      .clk(clk), .rst(rst), .x(xa), .y(ya), .o_active(act_a),
      .line_start(ls_a), .frame_start(fs_a), .rgb_in(rgb_in),
      .hsync(hs_a), .vsync(vs_a), .vga_rgb(rgb_a)
   );

   vga_timing #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(1'b0), .PIPE_DELAY(D_B)
   ) dut_b (
      .clk(clk), .rst(rst), .x(xb), .y(yb), .o_active(act_b),
      .line_start(ls_b), .frame_start(fs_b), .rgb_in(rgb_in),
      .hsync(hs_b), .vsync(vs_b), .vga_rgb(rgb_b)
   );

   // ---------------- reference model ----------------
   // {hs, vs, active} of the pixel issued at edge m (nothing before edge 0).
   function automatic logic [2:0] raw_at(input int m);
      int h;
      int v;
      if (m < 0) return 3'b000;
      h = m % HT;
      v = (m / HT) % VT;
      return {(h >= HA + HF) && (h < HA + HF + HS),
              (v >= VA + VF) && (v < VA + VF + VS),
              (h < HA) && (v < VA)};
   endfunction

   // Expected {hsync, vsync, vga_rgb} at the current edge.
   function automatic logic [10:0] exp_out(input int d, input logic pol);
      logic [2:0] r;
      r = raw_at(n - d - 1);
      return {r[2] ? pol : ~pol, r[1] ? pol : ~pol, r[0] ? edge_rgb : 9'h000};
   endfunction

   // Expected {x, y, o_active, line_start, frame_start} at the current edge.
   function automatic logic [23:0] exp_pos();
      int h;
      int v;
      h = n % HT;
      v = (n / HT) % VT;
      return {11'(h), 10'(v), (h < HA) && (v < VA), h == 0, (h == 0) && (v == 0)};
   endfunction

   task automatic tick();
      @(posedge clk);
      edge_rgb = rgb_in;
      n = n + 1;
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      rgb_in = 9'h1FF;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if ({hs_a, vs_a, rgb_a} !== {1'b0, 1'b0, 9'h000}) begin
            n_bad++;
            $display("FAIL reset_out_a cyc=%0d got %b/%b/%h want 0/0/000", i, hs_a, vs_a, rgb_a);
         end
         n_cmp++;
         if ({hs_b, vs_b, rgb_b} !== {1'b1, 1'b1, 9'h000}) begin
            n_bad++;
            $display("FAIL reset_out_b cyc=%0d got %b/%b/%h want 1/1/000", i, hs_b, vs_b, rgb_b);
         end
         n_cmp++;
         if ({xa, ya, act_a, ls_a, fs_a, xb, yb, act_b, ls_b, fs_b} !== 48'd0) begin
            n_bad++;
            $display("FAIL reset_pos cyc=%0d got x=%0d y=%0d act=%b ls=%b fs=%b want all 0",
                     i, xa, ya, act_a, ls_a, fs_a);
         end
      end
      rst = 1'b0;
      n = -1;
      rgb_in = 9'($urandom);
      tick();
      n_cmp++;
      if ({xa, ya, act_a, ls_a, fs_a} !== {11'd0, 10'd0, 3'b111}) begin
         n_bad++;
         $display("FAIL first_edge_a got x=%0d y=%0d act=%b ls=%b fs=%b want 0 0 1 1 1",
                  xa, ya, act_a, ls_a, fs_a);
      end
      n_cmp++;
      if ({xb, yb, act_b, ls_b, fs_b} !== {11'd0, 10'd0, 3'b111}) begin
         n_bad++;
         $display("FAIL first_edge_b got x=%0d y=%0d act=%b ls=%b fs=%b want 0 0 1 1 1",
                  xb, yb, act_b, ls_b, fs_b);
      end
   endtask

   task automatic test_raster(input int cycles);
      int last_fs;
      int fs_cnt;
      int hs_hi;
      int vs_hi;
      logic [23:0] ep;
      logic [10:0] ea;
      logic [10:0] eb;
      last_fs = -1;
      fs_cnt = 0;
      hs_hi = 0;
      vs_hi = 0;
      for (int i = 0; i < cycles; i++) begin
         rgb_in = 9'($urandom);
         tick();
         ep = exp_pos();
         ea = exp_out(D_A, 1'b1);
         eb = exp_out(D_B, 1'b0);
         n_cmp++;
         if ({xa, ya, act_a, ls_a, fs_a} !== ep) begin
            n_bad++;
            $display("FAIL raster_pos_a n=%0d got %h want %h", n, {xa, ya, act_a, ls_a, fs_a}, ep);
         end
         n_cmp++;
         if ({xb, yb, act_b, ls_b, fs_b} !== ep) begin
            n_bad++;
            $display("FAIL raster_pos_b n=%0d got %h want %h", n, {xb, yb, act_b, ls_b, fs_b}, ep);
         end
         n_cmp++;
         if ({hs_a, vs_a, rgb_a} !== ea) begin
            n_bad++;
            $display("FAIL raster_out_a n=%0d got %b/%b/%h want %b/%b/%h",
                     n, hs_a, vs_a, rgb_a, ea[10], ea[9], ea[8:0]);
         end
         n_cmp++;
         if ({hs_b, vs_b, rgb_b} !== eb) begin
            n_bad++;
            $display("FAIL raster_out_b n=%0d got %b/%b/%h want %b/%b/%h",
                     n, hs_b, vs_b, rgb_b, eb[10], eb[9], eb[8:0]);
         end
         if (i >= cycles - FRAME) begin
            if (hs_a === 1'b1) hs_hi++;
            if (vs_a === 1'b1) vs_hi++;
         end
         if (fs_a === 1'b1) begin
            fs_cnt++;
            if (last_fs >= 0) begin
               n_cmp++;
               if (n - last_fs != FRAME) begin
                  n_bad++;
                  $display("FAIL frame_period got %0d want %0d", n - last_fs, FRAME);
               end
            end
            last_fs = n;
         end
      end
      n_cmp++;
      if (fs_cnt != 2) begin
         n_bad++;
         $display("FAIL frame_count got %0d want 2", fs_cnt);
      end
      n_cmp++;
      if (hs_hi != HS * VT) begin
         n_bad++;
         $display("FAIL hsync_cycles_per_frame got %0d want %0d", hs_hi, HS * VT);
      end
      n_cmp++;
      if (vs_hi != VS * HT) begin
         n_bad++;
         $display("FAIL vsync_cycles_per_frame got %0d want %0d", vs_hi, VS * HT);
      end
   endtask

   task automatic test_blanking();
      int cnt_a;
      int cnt_b;
      logic [10:0] ea;
      cnt_a = 0;
      cnt_b = 0;
      rgb_in = 9'h1FF;
      for (int i = 0; i < FRAME; i++) begin
         tick();
         ea = exp_out(D_A, 1'b1);
         if (rgb_a !== 9'h000) cnt_a++;
         if (rgb_b !== 9'h000) cnt_b++;
         n_cmp++;
         if (rgb_a !== ea[8:0]) begin
            n_bad++;
            $display("FAIL blanking_rgb_a n=%0d got %h want %h", n, rgb_a, ea[8:0]);
         end
      end
      n_cmp++;
      if (cnt_a != HA * VA) begin
         n_bad++;
         $display("FAIL visible_count_a got %0d want %0d", cnt_a, HA * VA);
      end
      n_cmp++;
      if (cnt_b != HA * VA) begin
         n_bad++;
         $display("FAIL visible_count_b got %0d want %0d", cnt_b, HA * VA);
      end
   endtask

   task automatic test_color_align();
      logic found;
      found = 1'b0;
      rgb_in = 9'h000;
      for (int i = 0; i < 2 * FRAME && !found; i++) begin
         tick();
         if (xa == 11'(HA - 1) && ya < 10'(VA)) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin
         n_bad++;
         $display("FAIL align_wait got timeout want x=%0d", HA - 1);
      end else begin
         repeat (D_A) tick();
         rgb_in = 9'h1C0;
         tick();
         n_cmp++;
         if (rgb_a !== 9'h1C0) begin
            n_bad++;
            $display("FAIL align_last_pixel got %h want 1c0", rgb_a);
         end
         rgb_in = 9'h000;
         tick();
         n_cmp++;
         if (rgb_a !== 9'h000) begin
            n_bad++;
            $display("FAIL align_no_leak got %h want 000", rgb_a);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic found;
      logic [10:0] eb;
      logic want_hs;
      found = 1'b0;
      for (int i = 0; i < 2 * FRAME && !found; i++) begin
         rgb_in = 9'($urandom_range(1, 511));
         tick();
         if (xa == 11'(HA / 2) && ya == 10'(VA / 2)) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin
         n_bad++;
         $display("FAIL midreset_wait got timeout want x=%0d y=%0d", HA / 2, VA / 2);
      end else begin
         #2;
         rst = 1'b1;
         #1;
         n_cmp++;
         if ({xa, ya, act_a, ls_a, fs_a, hs_a, vs_a, rgb_a} !== 35'd0) begin
            n_bad++;
            $display("FAIL midreset_async_a got x=%0d y=%0d act=%b hs=%b vs=%b rgb=%h want zeros",
                     xa, ya, act_a, hs_a, vs_a, rgb_a);
         end
         n_cmp++;
         if ({xb, yb, act_b, ls_b, fs_b, hs_b, vs_b, rgb_b} !== {24'd0, 2'b11, 9'h000}) begin
            n_bad++;
            $display("FAIL midreset_async_b got x=%0d y=%0d hs=%b vs=%b rgb=%h want 0 0 1 1 000",
                     xb, yb, hs_b, vs_b, rgb_b);
         end
         repeat (3) tick();
         rst = 1'b0;
         n = -1;
         for (int k = 0; k <= HA + HF + D_A + 1; k++) begin
            rgb_in = 9'($urandom);
            tick();
            if (k == 0) begin
               n_cmp++;
               if ({xa, ya, fs_a} !== {11'd0, 10'd0, 1'b1}) begin
                  n_bad++;
                  $display("FAIL midreset_restart got x=%0d y=%0d fs=%b want 0 0 1", xa, ya, fs_a);
               end
            end
            want_hs = (k == HA + HF + D_A + 1);
            n_cmp++;
            if (hs_a !== want_hs) begin
               n_bad++;
               $display("FAIL midreset_hsync_a k=%0d got %b want %b", k, hs_a, want_hs);
            end
            eb = exp_out(D_B, 1'b0);
            n_cmp++;
            if ({hs_b, vs_b, rgb_b} !== eb) begin
               n_bad++;
               $display("FAIL midreset_out_b k=%0d got %b/%b/%h want %b/%b/%h",
                        k, hs_b, vs_b, rgb_b, eb[10], eb[9], eb[8:0]);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      n = -1;
      edge_rgb = 9'd0;
      test_reset();
      test_raster(2 * FRAME + 10);
      test_blanking();
      test_color_align();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
